// File: rtl/nios_pio_pkg.sv
// rtl/nios_pio_pkg.sv - shared edge-type encodings, register map and edge helper for the capture PIO
package nios_pio_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } addr_e;

    function automatic logic [31:0] edge_detect(input int edge_type,
                                                input logic [31:0] cur,
                                                input logic [31:0] prev);
        logic [31:0] result;
        result = '0;
        case (edge_type)
            EDGE_RISE: result = cur & ~prev;
            EDGE_FALL: result = ~cur & prev;
            default:   result = cur ^ prev;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/pio_sync_chain.sv
// rtl/pio_sync_chain.sv - multi-stage flop synchroniser for an asynchronous input bus
module pio_sync_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/noc_input_capture_pio.sv
// rtl/noc_input_capture_pio.sv - input PIO with synchronised edge capture, irq mask and registered read port
module noc_input_capture_pio
    import nios_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int BIT_CLEAR   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    localparam logic [2:0] PRIME_CYCLES = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] edge_now;
    logic [DATA_WIDTH-1:0] edge_q;
    logic [DATA_WIDTH-1:0] capture;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] clear_bits;
    logic [31:0]           read_next;
    logic [2:0]            prime_cnt;
    logic                  primed;
    logic                  wr;
    logic                  unused_wdata;

    assign unused_wdata = ^writedata;

    pio_sync_chain #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (sync_q)
    );

    // Detection stays off until prev_q has tracked the post-reset input level.
    assign primed   = (prime_cnt == PRIME_CYCLES);
    assign edge_now = DATA_WIDTH'(edge_detect(EDGE_TYPE, 32'(sync_q), 32'(prev_q)))
                      & {DATA_WIDTH{primed}};
    assign wr       = chipselect & ~write_n;

    always_comb begin
        clear_bits = '0;
        if (wr && address == ADDR_EDGE) begin
            clear_bits = (BIT_CLEAR != 0) ? writedata[DATA_WIDTH-1:0] : '1;
        end
    end

    always_comb begin
        read_next = '0;
        case (addr_e'(address))
            ADDR_DATA: read_next = 32'(sync_q);
            ADDR_MASK: read_next = 32'(irq_mask);
            ADDR_EDGE: read_next = 32'(capture);
            default:   read_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            prime_cnt <= '0;
            edge_q    <= '0;
            capture   <= '0;
            irq_mask  <= '0;
            readdata  <= '0;
        end else begin
            prev_q   <= sync_q;
            edge_q   <= edge_now;
            readdata <= read_next;
            if (!primed) begin
                prime_cnt <= prime_cnt + 3'd1;
            end
            // Set wins over clear on the same bit.
            capture <= (capture & ~clear_bits) | edge_q;
            if (wr && address == ADDR_MASK) begin
                irq_mask <= writedata[DATA_WIDTH-1:0];
            end
        end
    end

    assign irq = |(capture & irq_mask);

endmodule

// File: tb/tb_noc_input_capture_pio.sv
// tb/tb_noc_input_capture_pio.sv - self-checking bench for noc_input_capture_pio (rising/32-bit and any-edge/8-bit instances)
module tb_noc_input_capture_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in0;
    logic [7:0]  in1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        irq0;
    logic        irq1;

    int checks = 0;
    int fails  = 0;

    // Reference state: what software would see, derived from input history and bus writes.
    logic [31:0] cap0, mask0, cur0;
    logic [7:0]  cap1, mask1, cur1;

    always #5 clk = ~clk;

    noc_input_capture_pio #(
        .DATA_WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .BIT_CLEAR(1)
    ) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .irq(irq0)
    );

    noc_input_capture_pio #(
        .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .BIT_CLEAR(1)
    ) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in1), .irq(irq1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        if (a == 2'd2) begin
            mask0 = d;
            mask1 = d[7:0];
        end else if (a == 2'd3) begin
            cap0 = cap0 & ~d;
            cap1 = cap1 & ~d[7:0];
        end
    endtask

    task automatic apply_in(input logic [31:0] n0, input logic [7:0] n1);
        cap0 = cap0 | (n0 & ~cur0);
        cap1 = cap1 | (n1 ^ cur1);
        cur0 = n0;
        cur1 = n1;
        in0  = n0;
        in1  = n1;
        repeat (6) tick();
    endtask

    task automatic read_reg(input logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic check_all(input string tag);
        read_reg(2'd3);
        check({tag, " cap0"}, rd0, cap0);
        check({tag, " cap1"}, rd1, {24'd0, cap1});
        read_reg(2'd2);
        check({tag, " mask0"}, rd0, mask0);
        check({tag, " mask1"}, rd1, {24'd0, mask1});
        read_reg(2'd0);
        check({tag, " data1"}, rd1, {24'd0, cur1});
        check({tag, " irq0"}, {31'd0, irq0}, {31'd0, |(cap0 & mask0)});
        check({tag, " irq1"}, {31'd0, irq1}, {31'd0, |(cap1 & mask1)});
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        in0 = 32'h0000_00FF; in1 = 8'hA5;
        cur0 = in0; cur1 = in1; cap0 = '0; cap1 = '0; mask0 = '0; mask1 = '0;

        // Reset state
        repeat (3) tick();
        check("rst rd0", rd0, 32'd0);
        check("rst rd1", rd1, 32'd0);
        check("rst irq", {30'd0, irq1, irq0}, 32'd0);

        // Levels held through reset release are not captured
        @(negedge clk);
        reset = 1'b0;
        repeat (8) tick();
        read_reg(2'd3);
        check("prime cap0", rd0, 32'd0);
        check("prime cap1", rd1, 32'd0);
        check("prime irq0", {31'd0, irq0}, 32'd0);

        // Read of addr 0 has one cycle of latency, upper bits zero
        address = 2'd0;
        check("rd lat before", rd1, 32'd0);
        tick();
        check("rd addr0 dw8", rd1, 32'h0000_00A5);
        check("rd addr0 dw32", rd0, 32'h0000_00FF);

        // Rising edge on bit0 reaches capture (and irq) on the 4th edge
        apply_in(32'h0, cur1);
        bus_write(2'd2, 32'h1);
        in0 = 32'h1;
        cur0 = 32'h1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("lat edge%0d irq0", k), {31'd0, irq0}, {31'd0, k == 4});
        end
        cap0 = cap0 | 32'h1;
        check_all("lat");

        // Per-bit clear
        apply_in(32'h3, cur1);
        bus_write(2'd3, 32'h1);
        check("bitclr irq0 masked", {31'd0, irq0}, 32'd0);
        read_reg(2'd3);
        check("bitclr cap0", rd0, 32'h2);
        bus_write(2'd2, 32'h2);
        check("bitclr irq0 unmasked", {31'd0, irq0}, 32'd1);

        // Edge and clear on bit1 in the same cycle: set wins
        apply_in(32'h1, cur1);
        bus_write(2'd3, 32'h2);
        check("pri pre irq0", {31'd0, irq0}, 32'd0);
        in0 = 32'h3;
        cur0 = 32'h3;
        repeat (3) tick();
        bus_write(2'd3, 32'h2);
        cap0 = cap0 | 32'h2;
        check("pri irq0", {31'd0, irq0}, 32'd1);
        check_all("pri");

        // Any-edge pulse on bit3 with a clear between transitions
        apply_in(cur0, 8'hAD);
        bus_write(2'd3, 32'hFFFF_FFFF);
        apply_in(cur0, 8'hA5);
        check_all("pulse fall");
        bus_write(2'd3, 32'h8);
        apply_in(cur0, 8'hAD);
        check_all("pulse rise");
        bus_write(2'd2, 32'h8);
        check("pulse irq1", {31'd0, irq1}, 32'd1);

        // Reset mid-pulse clears everything asynchronously and drops pending edges
        in1 = 8'hA5;
        cur1 = 8'hA5;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async rd0", rd0, 32'd0);
        check("async rd1", rd1, 32'd0);
        check("async irq", {30'd0, irq1, irq0}, 32'd0);
        cap0 = '0; cap1 = '0; mask0 = '0; mask1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) tick();
        check_all("post rst");

        // Randomised input changes, masks and clears
        for (int i = 0; i < 24; i++) begin
            apply_in($urandom, 8'($urandom));
            if ($urandom_range(0, 1) == 1) bus_write(2'd2, $urandom);
            if ($urandom_range(0, 2) != 0) bus_write(2'd3, $urandom);
            check_all($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/noc_input_capture_pio.md
NOC_INPUT_CAPTURE_PIO -- requirements
Module: noc_input_capture_pio

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the in_port width; legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth; legal range 2..4.
REQ-003 SHALL have parameter EDGE_TYPE, default 0, selecting the capture edge: 0 rising, 1 falling, 2 any.
REQ-004 SHALL have parameter BIT_CLEAR, default 1: 1 clears individual capture bits on write; 0 clears all capture bits on any write.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port address, input, 2, Avalon-MM word address.
REQ-008 SHALL have port chipselect, input, 1, Avalon-MM slave select.
REQ-009 SHALL have port write_n, input, 1, Avalon-MM active-low write strobe.
REQ-010 SHALL have port writedata, input, 32, Avalon-MM write data.
REQ-011 SHALL have port readdata, output, 32, registered Avalon-MM read data.
REQ-012 SHALL have port in_port, input, DATA_WIDTH, asynchronous external input bus.
REQ-013 SHALL have port irq, output, 1, level interrupt to the processor.

Function
REQ-014 SHALL pass each in_port bit through a SYNC_STAGES flop chain; sync_q is the last stage.
REQ-015 SHALL register sync_q into prev_q every cycle.
REQ-016 SHALL detect edges per bit: rising = sync_q & ~prev_q; falling = ~sync_q & prev_q; any = sync_q ^ prev_q, per EDGE_TYPE.
REQ-017 SHALL keep edge detection disabled until a prime counter counts SYNC_STAGES+1 cycles after reset deassertion, so levels present at reset are never captured as edges.
REQ-018 SHALL set capture bit n one cycle after an enabled edge is detected on bit n; bits stay set until cleared.
REQ-019 SHALL decode a write when chipselect=1 and write_n=0.
REQ-020 SHALL, on a write to address 2, load irq_mask with writedata[DATA_WIDTH-1:0].
REQ-021 SHALL, on a write to address 3 with BIT_CLEAR=1, clear the capture bits where writedata is 1; with BIT_CLEAR=0, clear all capture bits.
REQ-022 SHALL give set priority over clear when an edge and a clear hit the same bit in the same cycle, so the bit ends set.
REQ-023 SHALL ignore writes to addresses 0 and 1.
REQ-024 SHALL update readdata every cycle from address, with latency 1: addr 0 sync_q; addr 1 zero; addr 2 irq_mask; addr 3 capture.
REQ-025 SHALL zero-extend readdata bits 31:DATA_WIDTH.
REQ-026 SHALL drive irq as OR-reduce(capture & irq_mask), derived only from registers with no combinational path from bus inputs.
REQ-027 SHALL give a total of SYNC_STAGES+2 clk edges from a stable in_port change to the capture bit being set.

Reset
REQ-028 SHALL asynchronously clear all synchroniser flops, prev_q, the prime counter, irq_mask, capture and readdata on reset=1; irq is 0 during reset.
REQ-029 SHALL restart the prime counter when reset is asserted mid-operation, and discard any pending capture.

Structure
REQ-030 SHALL place the EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY) and address map constants (ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3) in shared package nios_pio_pkg.
REQ-031 SHALL instantiate sub-module pio_sync_chain, parametrised by WIDTH and STAGES, for the synchroniser.

Verification
REQ-032 SHALL cover this case: hold in_port=32'h0000_00FF through reset release, then read addr 3 after the prime period -> 0, and irq=0.
REQ-033 SHALL cover this case: EDGE_TYPE=0, mask=32'h1, in_port bit0 0->1 -> capture=1 after exactly 4 edges at SYNC_STAGES=2, and irq=1 the same cycle.
REQ-034 SHALL cover this case: BIT_CLEAR=1, capture=32'h3, write 32'h1 to addr 3 -> capture=32'h2; irq follows the mask.
REQ-035 SHALL cover this case: an edge on bit1 in the same cycle as a clear write of 32'h2 -> bit1 remains set.
REQ-036 SHALL cover this case: DATA_WIDTH=8, in_port=8'hA5, read addr 0 -> readdata=32'h0000_00A5 one cycle after address is presented.
REQ-037 SHALL cover this case: EDGE_TYPE=2, a pulse 1->0->1 on bit3 with clear in between -> bit3 captured on each transition; reset asserted mid-pulse -> all registers 0 and irq=0 asynchronously.
